// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys rewound on the fly.
// Optional macro AES_DEC_ABORT_EN adds an abort input that cancels a running job.
module aes_dec_iter #(
  parameter int NR = 10
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         enable,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] i_text,
  input  logic [127:0] key,
  output logic [127:0] o_text,
  output logic [127:0] Rkey,
  output logic         ready,
  output logic         done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]   r_state;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [3:0]   r_rnd;

  logic [127:0] w_rk_prev;
  logic [127:0] w_add;
  logic [127:0] w_next;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Undoes one forward key-expansion step; byte 0 of each word sits in the low bits.
  function automatic logic [127:0] inv_exp(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[127:96] ^ k[95:64];
    p2 = k[95:64]  ^ k[63:32];
    p1 = k[63:32]  ^ k[31:0];
    p0 = k[31:0] ^ sub_word({p3[7:0], p3[31:8]}) ^ {24'h0, rcon(r)};
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   b0, b1, b2, b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[32*c +: 8];
      b1 = s[32*c + 8 +: 8];
      b2 = s[32*c + 16 +: 8];
      b3 = s[32*c + 24 +: 8];
      o[32*c +: 8]      = gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09);
      o[32*c + 8 +: 8]  = gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d);
      o[32*c + 16 +: 8] = gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b);
      o[32*c + 24 +: 8] = gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e);
    end
    return o;
  endfunction

  assign w_rk_prev = inv_exp(r_rk, r_rnd);
  assign w_add     = inv_sub_bytes(inv_shift_rows(r_st)) ^ w_rk_prev;
  assign w_next    = (r_rnd == 4'd1) ? w_add : inv_mix_columns(w_add);
  assign ready     = (r_state == S_IDLE);

  // NOTE: datapath registers are reset along with control so a mid-run reset leaves no stale state visible.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_st    <= '0;
      r_rk    <= '0;
      r_rnd   <= '0;
      o_text  <= '0;
      Rkey    <= '0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values, so the last-round test and the update agree.
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_st    <= i_text ^ key;
            r_rk    <= key;
            r_rnd   <= 4'(NR);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef AES_DEC_ABORT_EN
          if (abort) begin
            r_state <= S_IDLE;
            r_rnd   <= '0;
          end else
`endif
          begin
            r_st  <= w_next;
            r_rk  <= w_rk_prev;
            r_rnd <= r_rnd - 4'd1;
            if (r_rnd == 4'd1) begin
              o_text  <= w_next;
              Rkey    <= w_rk_prev;
              done    <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Self-checking bench for aes_dec_iter: FIPS-197 vectors, back-to-back, ignored enable, reset and abort.
module tb_aes_dec_iter;

  logic         clock = 1'b0;
  logic         resetn;
  logic         enable;
  logic [127:0] i_text;
  logic [127:0] key;
  logic [127:0] o_text;
  logic [127:0] Rkey;
  logic         ready;
  logic         done;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  aes_dec_iter #(.NR(10)) dut (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
`ifdef AES_DEC_ABORT_EN
    .abort  (abort),
`endif
    .i_text (i_text),
    .key    (key),
    .o_text (o_text),
    .Rkey   (Rkey),
    .ready  (ready),
    .done   (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ck;
    string        name;
  } vec_t;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ck;
    int           exp_edge;
    string        name;
  } exp_t;

  vec_t vecs[2];
  exp_t sb_q[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding job, on its scheduled edge.
  always @(negedge clock) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      check("done_expected", 128'(sb_q.size() != 0), 128'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_text"}, o_text, mon_e.pt);
        check({mon_e.name, "_rkey"}, Rkey, mon_e.ck);
        check({mon_e.name, "_latency"}, 128'(edge_cnt), 128'(mon_e.exp_edge));
      end
    end
  end

  // Called at a negedge; drives enable for the next edge (E0) and returns at the negedge after E0.
  task automatic start(input vec_t v, input string nm, input bit expect_done);
    exp_t e;
    i_text = v.ct;
    key    = v.key;
    enable = 1'b1;
    if (expect_done) begin
      e.pt       = v.pt;
      e.ck       = v.ck;
      e.exp_edge = edge_cnt + 11;
      e.name     = nm;
      sb_q.push_back(e);
    end
    @(negedge clock);
    enable = 1'b0;
    i_text = ~v.ct;
    key    = ~v.key;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clock);
    check({nm, "_drain_timeout"}, 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].ct   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    vecs[0].key  = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    vecs[0].pt   = 128'hffeeddccbbaa99887766554433221100;
    vecs[0].ck   = 128'h0f0e0d0c0b0a09080706050403020100;
    vecs[0].name = "fips_c1";
    vecs[1].ct   = 128'h320b6a19978511dcfb09dc021d842539;
    vecs[1].key  = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    vecs[1].pt   = 128'h340737e0a29831318d305a88a8f64332;
    vecs[1].ck   = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    vecs[1].name = "fips_b";

    resetn = 1'b0;
    enable = 1'b0;
    i_text = '0;
    key    = '0;
`ifdef AES_DEC_ABORT_EN
    abort  = 1'b0;
`endif
    #3;
    check("reset_o_text", o_text, 128'd0);
    check("reset_rkey", Rkey, 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_ready", 128'(ready), 128'd1);
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven single jobs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      start(vecs[i], vecs[i].name, 1'b1);
      check({vecs[i].name, "_ready_low"}, 128'(ready), 128'd0);
      drain(vecs[i].name);
    end

    // Back-to-back: second enable on the cycle where done is high.
    @(negedge clock);
    start(vecs[0], "b2b_first", 1'b1);
    repeat (9) @(negedge clock);
    @(negedge clock);
    check("b2b_done_high", 128'(done), 128'd1);
    check("b2b_ready_high", 128'(ready), 128'd1);
    start(vecs[1], "b2b_second", 1'b1);
    drain("b2b");

    // Enable pulses with different data during RUN must be ignored.
    @(negedge clock);
    start(vecs[0], "ign_en", 1'b1);
    for (int k = 0; k < 10; k++) begin
      check("ign_ready_low", 128'(ready), 128'd0);
      i_text = vecs[1].ct;
      key    = vecs[1].key;
      enable = (k < 9) && (k % 2 == 0);
      @(negedge clock);
    end
    enable = 1'b0;
    drain("ign_en");
    repeat (12) @(negedge clock);

    // Asynchronous reset at E5: outputs clear without waiting for an edge, and no done follows.
    @(negedge clock);
    start(vecs[0], "rst", 1'b0);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_o_text", o_text, 128'd0);
    check("midrst_rkey", Rkey, 128'd0);
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_done", 128'(done), 128'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (12) @(negedge clock);
    start(vecs[1], "after_rst", 1'b1);
    drain("after_rst");

`ifdef AES_DEC_ABORT_EN
    // Abort at E4 keeps the previous job's outputs.
    @(negedge clock);
    start(vecs[1], "pre_abort", 1'b1);
    drain("pre_abort");
    @(negedge clock);
    start(vecs[0], "abort", 1'b0);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_ready", 128'(ready), 128'd1);
    check("abort_done", 128'(done), 128'd0);
    check("abort_o_text_kept", o_text, vecs[1].pt);
    check("abort_rkey_kept", Rkey, vecs[1].ck);
    repeat (12) @(negedge clock);

    // Abort together with enable in IDLE: enable wins.
    abort = 1'b1;
    start(vecs[0], "abort_with_en", 1'b1);
    abort = 1'b0;
    drain("abort_with_en");
`endif

    repeat (4) @(negedge clock);
    check("final_queue_empty", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
